// File: rtl/register_pkg.sv
// Shared helpers for storage blocks: even parity over any width up to PAR_MAX_W.
package register_pkg;

  localparam int PAR_MAX_W = 1024;

  // Zero-extension does not change parity, so callers pad narrower data.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/parity_gen.sv
// Even-parity generator: one bit that makes the total count of ones even.
module parity_gen
  import register_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] d,
  output logic             par
);

  logic [PAR_MAX_W-1:0] d_ext;

  assign d_ext = PAR_MAX_W'(d);
  assign par   = even_parity(d_ext);

endmodule

// File: rtl/register_en_clr.sv
// Pipeline register with load enable and synchronous clear (flush).
// Optional stored parity and sticky perr flag under `REGISTER_PARITY_EN.
module register_en_clr
  import register_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             en,
  input  logic             clear,
  input  logic [WIDTH-1:0] D,
`ifdef REGISTER_PARITY_EN
  output logic             perr,
`endif
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] q_r;

  // rst_l is active-high; clear outranks en so a flush drops any pending load.
  always_ff @(posedge clk) begin
    if (rst_l)      q_r <= RESET_VAL;
    else if (clear) q_r <= RESET_VAL;
    else if (en)    q_r <= D;
  end

  assign Q = q_r;

`ifdef REGISTER_PARITY_EN
  localparam logic RST_PAR = even_parity(PAR_MAX_W'(RESET_VAL));

  logic d_par, q_par, par_r, perr_r;

  parity_gen #(.WIDTH(WIDTH)) u_par_d (.d(D),   .par(d_par));
  parity_gen #(.WIDTH(WIDTH)) u_par_q (.d(q_r), .par(q_par));

  // perr is sticky: only reset or clear bring it back down.
  always_ff @(posedge clk) begin
    if (rst_l || clear) begin
      par_r  <= RST_PAR;
      perr_r <= 1'b0;
    end else begin
      if (en) par_r <= d_par;
      perr_r <= perr_r | (q_par ^ par_r);
    end
  end

  assign perr = perr_r;
`endif

endmodule

// File: tb/tb_register_en_clr.sv
// Scoreboard bench for register_en_clr: three instances (WIDTH 1, 15, 12).
// Parity checks compile only with `REGISTER_PARITY_EN.
module tb_register_en_clr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, en_a, clr_a;
  logic [0:0]  d_a, q_a;
  logic        rst_b, en_b, clr_b;
  logic [14:0] d_b, q_b;
  logic        rst_c, en_c, clr_c;
  logic [11:0] d_c, q_c;
`ifdef REGISTER_PARITY_EN
  logic perr_a, perr_b, perr_c;
`endif

  register_en_clr #(.WIDTH(1), .RESET_VAL(1'b0)) dut_a (
    .clk(clk), .rst_l(rst_a), .en(en_a), .clear(clr_a), .D(d_a),
`ifdef REGISTER_PARITY_EN
    .perr(perr_a),
`endif
    .Q(q_a));

  register_en_clr #(.WIDTH(15), .RESET_VAL(15'o0)) dut_b (
    .clk(clk), .rst_l(rst_b), .en(en_b), .clear(clr_b), .D(d_b),
`ifdef REGISTER_PARITY_EN
    .perr(perr_b),
`endif
    .Q(q_b));

  register_en_clr #(.WIDTH(12), .RESET_VAL(12'o4000)) dut_c (
    .clk(clk), .rst_l(rst_c), .en(en_c), .clear(clr_c), .D(d_c),
`ifdef REGISTER_PARITY_EN
    .perr(perr_c),
`endif
    .Q(q_c));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference registers and scoreboard queues
  logic [0:0]  m_a;
  logic [14:0] m_b;
  logic [11:0] m_c;
  logic [31:0] sb_a[$], sb_b[$], sb_c[$];

  task automatic step();
    m_a = rst_a ? 1'b0     : clr_a ? 1'b0     : en_a ? d_a : m_a;
    m_b = rst_b ? 15'o0    : clr_b ? 15'o0    : en_b ? d_b : m_b;
    m_c = rst_c ? 12'o4000 : clr_c ? 12'o4000 : en_c ? d_c : m_c;
    sb_a.push_back(32'(m_a));
    sb_b.push_back(32'(m_b));
    sb_c.push_back(32'(m_c));
    @(posedge clk);
    #1;
    chk("sb_a", 32'(q_a), sb_a.pop_front());
    chk("sb_b", 32'(q_b), sb_b.pop_front());
    chk("sb_c", 32'(q_c), sb_c.pop_front());
  endtask

  task automatic idle_all();
    rst_a = 0; en_a = 0; clr_a = 0;
    rst_b = 0; en_b = 0; clr_b = 0;
    rst_c = 0; en_c = 0; clr_c = 0;
  endtask

  initial begin
    m_a = 'x; m_b = 'x; m_c = 'x;
    // Reset held for two edges with en=1 and D=1
    rst_a = 1; en_a = 1; clr_a = 0; d_a = 1'b1;
    rst_b = 1; en_b = 1; clr_b = 0; d_b = 15'o77777;
    rst_c = 1; en_c = 1; clr_c = 0; d_c = 12'o7777;
    step();
    step();
    chk("rst_a", 32'(q_a), 32'h0);
    chk("rst_b", 32'(q_b), 32'h0);
    chk("rst_c", 32'(q_c), 32'o4000);
`ifdef REGISTER_PARITY_EN
    chk("rst_perr", 32'({perr_a, perr_b, perr_c}), 32'h0);
`endif
    // First load on the first edge with reset sampled low
    idle_all();
    en_a = 1; d_a = 1'b1;
    step();
    chk("rst_release", 32'(q_a), 32'h1);

    // Flush beats load, then load resumes
    clr_a = 1; en_a = 1; d_a = 1'b1;
    step();
    chk("flush_wins", 32'(q_a), 32'h0);
    clr_a = 0;
    step();
    chk("after_flush", 32'(q_a), 32'h1);

    // Hold on WIDTH=15
    en_b = 1; d_b = 15'o12345;
    step();
    en_b = 0; d_b = 15'o77777;
    repeat (3) step();
    chk("hold", 32'(q_b), 32'o12345);

    // Non-zero reset value on clear
    en_c = 1; d_c = 12'o0017;
    step();
    chk("load_c", 32'(q_c), 32'o0017);
    clr_c = 1;
    step();
    chk("clear_c", 32'(q_c), 32'o4000);
    clr_c = 0;

    // One-cycle pulse on WIDTH=1
    en_a = 1; clr_a = 1; d_a = 1'b0;
    step();
    clr_a = 0; d_a = 1'b1;
    step();
    chk("pulse_hi", 32'(q_a), 32'h1);
    d_a = 1'b0;
    step();
    chk("pulse_lo", 32'(q_a), 32'h0);
    step();
    chk("pulse_lo2", 32'(q_a), 32'h0);

    // Reset mid-stream with a pending load, and all three controls at once
    en_c = 1; d_c = 12'o1234;
    step();
    rst_c = 1; d_c = 12'o5555;
    step();
    chk("mid_rst", 32'(q_c), 32'o4000);
    rst_c = 1; clr_c = 1; en_c = 1; d_c = 12'o6666;
    step();
    chk("rst_clr_en", 32'(q_c), 32'o4000);
    idle_all();

    // Randomised traffic on all three instances
    for (int i = 0; i < 80; i++) begin
      rst_a = ($urandom_range(0, 15) == 0); clr_a = ($urandom_range(0, 5) == 0);
      en_a  = $urandom_range(0, 1);         d_a   = 1'($urandom);
      rst_b = ($urandom_range(0, 15) == 0); clr_b = ($urandom_range(0, 5) == 0);
      en_b  = $urandom_range(0, 1);         d_b   = 15'($urandom);
      rst_c = ($urandom_range(0, 15) == 0); clr_c = ($urandom_range(0, 5) == 0);
      en_c  = $urandom_range(0, 1);         d_c   = 12'($urandom);
      step();
    end
    idle_all();

`ifdef REGISTER_PARITY_EN
    // Corrupt a stored bit and watch perr rise, stick, then clear
    en_c = 1; d_c = 12'h0A5;
    step();
    en_c = 0;
    step();
    chk("perr_clean", 32'(perr_c), 32'h0);
    force dut_c.q_r = 12'h0A4;
    @(posedge clk);
    #1;
    chk("perr_set", 32'(perr_c), 32'h1);
    release dut_c.q_r;
    @(posedge clk);
    #1;
    chk("perr_sticky", 32'(perr_c), 32'h1);
    m_c = q_c;
    clr_c = 1;
    step();
    chk("perr_cleared", 32'(perr_c), 32'h0);
    idle_all();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/register_en_clr.md
# register_en_clr

Parameterised pipeline register with load enable and synchronous clear. It is the basic storage element between pipeline stages, for example the decoder's one-bit extracode and index flags that must survive exactly one cycle and drop on a pipeline flush. It is purely sequential: one clocked stage with no combinational path from `D` to `Q`.

## Interface
Parameters:
- `WIDTH`, default 32: data width in bits; must be ≥ 1.
- `RESET_VAL`, default all zeros: value loaded on reset and on clear; `WIDTH` bits wide.

Ports (one clock; reset is synchronous and active-high):
- `clk` input, 1: clock; all state updates on its rising edge.
- `rst_l` input, 1: synchronous reset, active-high despite the `_l` suffix; sampled only at the rising edge of `clk`.
- `en` input, 1: load enable.
- `clear` input, 1: synchronous clear, the pipeline flush.
- `D` input, `WIDTH`: next data.
- `Q` output, `WIDTH`: registered data.
- `perr` output, 1: parity error flag; present only when `REGISTER_PARITY_EN` is defined.

## Operation
- Priority at each rising edge, highest first:
  - `rst_l`=1: `Q` ← `RESET_VAL`.
  - else `clear`=1: `Q` ← `RESET_VAL`, regardless of `en`.
  - else `en`=1: `Q` ← `D`.
  - else: `Q` holds.
- `RESET_VAL` is truncated or zero-extended to `WIDTH` bits.
- No combinational path from any input to `Q`.
- X on `en` or `clear` while reset is deasserted propagates X into `Q` in simulation. The design does not mask it.

## Timing
- Latency is one cycle: `D` sampled at edge N appears on `Q` immediately after edge N and stays until the next qualifying edge.
- Reset value of `Q` is `RESET_VAL`. Reset value of `perr` is 0.
- `Q` holds its value before the first clock edge is undefined. The bench must assert `rst_l` for at least one edge.
- Simultaneous reset, clear and en: reset wins; the result equals clear anyway.
- Simultaneous clear and en: clear wins and `D` is discarded. This is the flush-during-load case.
- Reset asserted mid-stream: `Q` goes to `RESET_VAL` on the same edge; a pending `D` is lost.
- Deasserting reset with `en`=1: the first load happens on the first edge at which `rst_l` is sampled 0.

## Configuration
- Macro `REGISTER_PARITY_EN`.
- When defined:
  - An extra even-parity bit is stored alongside `Q`. It is loaded with parity(`D`) on `en` loads and with parity(`RESET_VAL`) on reset or clear.
  - `perr` is a registered flag, set on the edge after the recomputed parity of `Q` differs from the stored bit.
  - `perr` is sticky until reset or clear.
- When undefined: no parity bit, no `perr` port, zero overhead.

## Structure
- No shared typedefs are required. The even-parity function belongs in the shared package `register_pkg` so other storage blocks can reuse it.
- One optional sub-module, `parity_gen` (`WIDTH` input bits → 1 parity bit), instantiated only under `REGISTER_PARITY_EN`.
- Clear-over-enable priority must be coded as a single prioritised branch, not as separate always blocks.

## Test plan
- Reset: `WIDTH`=1, `RESET_VAL`=0, `D`=1, `en`=1, `rst_l`=1 for 2 edges → `Q`=0; after `rst_l`=0, the next edge gives `Q`=1.
- Hold: `WIDTH`=15, load `D`=15'o12345, then `en`=0 with `D`=15'o77777 for 3 edges → `Q` stays 15'o12345.
- Flush beats load: `Q`=1, `clear`=1, `en`=1, `D`=1 → `Q`=0 after one edge; the next edge with `clear`=0, `en`=1 gives `Q`=1.
- Non-zero reset value: `WIDTH`=12, `RESET_VAL`=12'o4000, load 12'o0017, then `clear`=1 → `Q`=12'o4000.
- One-cycle pulse: `D`=1 for one edge, then `D`=0, `en`=1 throughout → `Q` high for exactly one cycle, one edge late.
- Parity (macro defined): load 8'hA5 → `perr`=0; force one bit of `Q` to flip → `perr`=1 on the next edge; `clear` returns `perr` to 0.
